// File: rtl/dmem_load_seq_pkg.sv
// dmem_load_seq_pkg: shared load funct3 codes, FSM encoding and alignment helper
package dmem_load_seq_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RSP  = 2'd3
  } state_e;
  // Undefined funct3 codes fall into the word case, so they behave as lw.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3 == LB || f3 == LBU) ? 1'b0 : (f3 == LH || f3 == LHU) ? (off == 2'b11) : (off != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: picks 4 consecutive bytes out of two adjacent big-endian-lane words
module dmem_byte_merge (
  input  logic [31:0] lo_word_i,
  input  logic [31:0] hi_word_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] word_o
);
  logic [63:0] pair;
  assign pair = {lo_word_i, hi_word_i};
  // Lowest byte address sits in the top lane, so a larger offset slides the window down.
  always_comb begin
    word_o = offset_i == 2'd0 ? pair[63:32] :
             offset_i == 2'd1 ? pair[55:24] :
             offset_i == 2'd2 ? pair[47:16] : pair[39:8];
  end
endmodule

// File: rtl/dmem_load_seq.sv
// dmem_load_seq: sequences BRAM reads for loads; define DMEM_LOAD_SPLIT_EN to split misaligned loads into two reads
module dmem_load_seq
  import dmem_load_seq_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_funct3,
  output logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_byte_offset,
  output logic [2:0]        rsp_dm_select,
  output logic              rsp_misaligned
);
  state_e            state_q;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              mis_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [ADDR_W-1:0] dm_addr_d;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic [1:0]        rsp_off_q;
  logic [2:0]        rsp_sel_q;
  logic              rsp_mis_q;
  logic              accept;
  logic              split_go;
  logic              unused_addr;
  assign req_ready   = nrst && state_q == IDLE;
  assign accept      = req_valid && req_ready;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
`ifdef DMEM_LOAD_SPLIT_EN
  logic [31:0] word0_q;
  logic [31:0] merged;
  assign split_go = state_q == RD0 && mis_q;
  dmem_byte_merge u_merge (
    .lo_word_i (word0_q),
    .hi_word_i (dm_rdata),
    .offset_i  (addr_q[1:0]),
    .word_o    (merged)
  );
`else
  assign split_go = 1'b0;
`endif
  // BRAM address: new request on accept, next word while splitting, otherwise hold.
  always_comb begin
    dm_addr_d = accept ? req_addr[ADDR_W+1:2] : split_go ? addr_q[ADDR_W+1:2] + ADDR_W'(1) : dm_addr_q;
  end
  assign dm_addr         = dm_addr_d;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_byte_offset = rsp_off_q;
  assign rsp_dm_select   = rsp_sel_q;
  assign rsp_misaligned  = rsp_mis_q;
  // Load FSM with registered response fields held until the writeback handshake.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      mis_q       <= 1'b0;
      dm_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_off_q   <= '0;
      rsp_sel_q   <= '0;
      rsp_mis_q   <= 1'b0;
`ifdef DMEM_LOAD_SPLIT_EN
      word0_q     <= '0;
`endif
    end else begin
      dm_addr_q <= dm_addr_d;
      case (state_q)
        IDLE: if (accept) begin
          addr_q   <= req_addr[ADDR_W+1:0];
          funct3_q <= req_funct3;
          mis_q    <= is_misaligned(req_funct3, req_addr[1:0]);
          state_q  <= RD0;
        end
        RD0: if (split_go) begin
`ifdef DMEM_LOAD_SPLIT_EN
          word0_q <= dm_rdata;
`endif
          state_q <= RD1;
        end else begin
          rsp_data_q  <= dm_rdata;
          rsp_off_q   <= addr_q[1:0];
          rsp_sel_q   <= funct3_q;
          rsp_mis_q   <= mis_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
`ifdef DMEM_LOAD_SPLIT_EN
        RD1: begin
          rsp_data_q  <= merged;
          rsp_off_q   <= 2'b00;
          rsp_sel_q   <= funct3_q;
          rsp_mis_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
`endif
        RSP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_load_seq.sv
// tb_dmem_load_seq: directed load sequence with a BRAM model and response scoreboard
module tb_dmem_load_seq;
  localparam int AW = 12;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  off;
    logic [2:0]  sel;
    logic        mis;
  } rsp_t;
  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_rdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_byte_offset;
  logic [2:0]    rsp_dm_select;
  logic          rsp_misaligned;
  logic [31:0]   mem [0:(1<<AW)-1];
  rsp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;

  dmem_load_seq #(.ADDR_W(AW)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_funct3      (req_funct3),
    .dm_addr         (dm_addr),
    .dm_rdata        (dm_rdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_byte_offset (rsp_byte_offset),
    .rsp_dm_select   (rsp_dm_select),
    .rsp_misaligned  (rsp_misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) dm_rdata <= mem[dm_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: gather bytes address by address, independent of lane-window arithmetic.
  function automatic rsp_t model(input logic [31:0] a, input logic [2:0] f3, output int lat);
    int   size;
    logic mis;
    rsp_t r;
    size   = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    mis    = (int'(a[1:0]) + size) > 4;
    lat    = 2;
    r.data = mem[a[AW+1:2]];
    r.off  = a[1:0];
    r.sel  = f3;
    r.mis  = mis;
`ifdef DMEM_LOAD_SPLIT_EN
    r.mis = 1'b0;
    if (mis) begin
      lat   = 3;
      r.off = 2'b00;
      for (int k = 0; k < 4; k++) begin
        logic [31:0] b;
        logic [31:0] w;
        int          lane;
        b    = a + 32'(k);
        w    = mem[b[AW+1:2]];
        lane = int'(b[1:0]);
        r.data[31-8*k -: 8] = w[31-8*lane -: 8];
      end
    end
`endif
    return r;
  endfunction

  // Scoreboard: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst && rsp_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_rsp: observed rsp_valid=1 expected 0 (no request pending)");
      end
      if (rsp_ready && exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_byte_offset", 32'(rsp_byte_offset), 32'(e.off));
        chk("rsp_dm_select", 32'(rsp_dm_select), 32'(e.sel));
        chk("rsp_misaligned", 32'(rsp_misaligned), 32'(e.mis));
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input string tag);
    rsp_t          r;
    int            lat;
    int            n;
    logic [AW-1:0] w;
    logic [AW-1:0] w1;
    r  = model(a, f3, lat);
    w  = a[AW+1:2];
    w1 = w + 1'b1;
    exp_q.push_back(r);
    req_valid = 1'b1; req_addr = a; req_funct3 = f3;
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " dm_addr_accept"}, 32'(dm_addr), 32'(w));
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, " dm_addr_rd0"}, 32'(dm_addr), 32'(lat == 3 ? w1 : w));
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    @(posedge clk); #1;
    chk({tag, " drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    rsp_t r;
    int   lat;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i) * 32'h9E3779B1 + 32'h01234567;
    mem[12'h040] = 32'h11223344;
    #2 nrst = 1'b0;
    #1;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_data", rsp_data, 32'd0);
    chk("rst rsp_byte_offset", 32'(rsp_byte_offset), 32'd0);
    chk("rst rsp_dm_select", 32'(rsp_dm_select), 32'd0);
    chk("rst rsp_misaligned", 32'(rsp_misaligned), 32'd0);
    chk("rst dm_addr", 32'(dm_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    #1 chk("rst req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    do_load(32'h100, 3'b010, "lw_0x100");
    do_load(32'h103, 3'b100, "lbu_0x103");
    do_load(32'h102, 3'b001, "lh_0x102");
    do_load(32'h101, 3'b000, "lb_0x101");
    do_load(32'h101, 3'b101, "lhu_0x101");
    mem[12'h040] = 32'hAABBCCDD;
    mem[12'h041] = 32'h11223344;
    do_load(32'h102, 3'b010, "lw_0x102");
    do_load(32'h3FFF, 3'b001, "lh_wrap");
    do_load(32'h3FFE, 3'b101, "lhu_last_off2");
    do_load(32'h105, 3'b011, "f3_011_as_lw");
    do_load(32'h108, 3'b110, "f3_110_aligned");
    do_load(32'h3FFD, 3'b111, "f3_111_wrap");
    // writeback stall: response must hold and the BRAM address must not move
    r = model(32'h204, 3'b010, lat);
    exp_q.push_back(r);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h204; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall rsp_valid_hold", 32'(rsp_valid), 32'd1);
      chk("stall rsp_data_hold", rsp_data, r.data);
      chk("stall offset_hold", 32'(rsp_byte_offset), 32'(r.off));
      chk("stall req_ready", 32'(req_ready), 32'd0);
      chk("stall dm_addr_hold", 32'(dm_addr), 32'h081);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall released", 32'(rsp_valid), 32'd0);
    chk("stall drained", 32'(exp_q.size()), 32'd0);
    // upstream holds a second request while busy; it is taken only after the handshake
    r = model(32'h200, 3'b010, lat);
    exp_q.push_back(r);
    r = model(32'h207, 3'b100, lat);
    exp_q.push_back(r);
    req_valid = 1'b1; req_addr = 32'h200; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_addr = 32'h207; req_funct3 = 3'b100;
    chk("b2b busy_rd0", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b busy_rsp", 32'(req_ready), 32'd0);
    chk("b2b dm_addr_held", 32'(dm_addr), 32'h080);
    @(posedge clk); #1;
    chk("b2b idle_again", 32'(req_ready), 32'd1);
    chk("b2b dm_addr_second", 32'(dm_addr), 32'h081);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b second_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    chk("b2b drained", 32'(exp_q.size()), 32'd0);
    // reset while a misaligned load is in flight discards it
    req_valid = 1'b1; req_addr = 32'h102; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef DMEM_LOAD_SPLIT_EN
    @(posedge clk); #1;
`endif
    nrst = 1'b0;
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst rsp_data", rsp_data, 32'd0);
    chk("midrst rsp_byte_offset", 32'(rsp_byte_offset), 32'd0);
    chk("midrst rsp_dm_select", 32'(rsp_dm_select), 32'd0);
    chk("midrst rsp_misaligned", 32'(rsp_misaligned), 32'd0);
    chk("midrst dm_addr", 32'(dm_addr), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("postrst no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("postrst req_ready", 32'(req_ready), 32'd1);
    do_load(32'h104, 3'b010, "lw_after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_load_seq.md
DMEM_LOAD_SEQ -- requirements
Module: dmem_load_seq

Interface
REQ-001 Parameter ADDR_W, default 12: data-memory word-address width.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 nrst  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  load request from EX/MEM stage.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_addr  input  32  byte address (ALU result).
REQ-007 req_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-008 dm_addr  output  ADDR_W  word address to BRAM DATAMEM; read data is valid one cycle later.
REQ-009 dm_rdata  input  32  BRAM read word; byte at word offset 0 in [31:24], offset 3 in [7:0].
REQ-010 rsp_valid  output  1  response word ready for the load-extract stage.
REQ-011 rsp_ready  input  1  writeback accepts response.
REQ-012 rsp_data, rsp_byte_offset, rsp_dm_select  output  32/2/3  word, offset and funct3 for the load-extract stage.
REQ-013 rsp_misaligned  output  1  access not served by a split (see Configuration).

Function
REQ-014 FSM states: IDLE, RD0, RD1, RSP; req_ready=1 only in IDLE.
REQ-015 Accept on req_valid&&req_ready; register addr and funct3; dm_addr=req_addr[ADDR_W+1:2] combinationally in the accept cycle; IDLE->RD0.
REQ-016 Misaligned := (funct3[1:0]==01 && addr[1:0]==3) || (funct3[1:0]==10 && addr[1:0]!=0); byte loads never misaligned.
REQ-017 RD0: capture dm_rdata into word0; aligned -> RSP with rsp_data=word0, rsp_byte_offset=addr[1:0]; misaligned -> drive dm_addr=(A+1) mod 2^ADDR_W, go RD1.
REQ-018 RD1: rsp_data = 4 bytes starting at byte address addr, taken from word0 then dm_rdata, lowest address in [31:23+1]; rsp_byte_offset=0; go RSP.
REQ-019 rsp_dm_select = registered funct3 unchanged; undefined funct3 (011,110,111) handled as lw.
REQ-020 Latency accept-to-rsp_valid: 2 cycles aligned, 3 cycles split.
REQ-021 RSP: rsp_valid=1, all rsp_* stable until rsp_valid&&rsp_ready; then IDLE; no new accept in that same cycle.
REQ-022 dm_addr outside accept/RD0 holds last value; requests during non-IDLE are not accepted and not lost by the block (upstream holds).

Reset
REQ-023 nrst low: state IDLE, rsp_valid=0, rsp_data=0, rsp_byte_offset=0, rsp_dm_select=0, rsp_misaligned=0, dm_addr=0, req_ready=1 after release.
REQ-024 Reset mid-transaction discards it; no response emitted.

Configuration
REQ-025 Macro DMEM_LOAD_SPLIT_EN defined: misaligned loads split per REQ-017/018, rsp_misaligned=0.
REQ-026 Macro undefined: misaligned loads served as aligned single read, RD1 unreachable, rsp_misaligned=1 with response; rsp_misaligned constant 0 otherwise.

Structure
REQ-027 Shared package holds funct3 load constants (LB, LH, LW, LBU, LHU) and FSM state encoding.
REQ-028 One sub-module dmem_byte_merge: combinational 8-byte-to-4-byte selector by offset.

Verification
REQ-029 lw addr 0x100, mem[0x40]=0x11223344 -> rsp at +2 cycles: data 0x11223344, offset 0, select 010.
REQ-030 lbu addr 0x103 -> single read, rsp_byte_offset 3, data = raw word, latency 2.
REQ-031 SPLIT_EN, lw addr 0x102, mem[0x40]=0xAABBCCDD, mem[0x41]=0x11223344 -> latency 3, data 0xCCDD1122, offset 0.
REQ-032 SPLIT_EN, lh addr at last word offset 3 -> second dm_addr wraps to 0.
REQ-033 rsp_ready low 5 cycles -> rsp_* stable, req_ready 0, no BRAM reads.
REQ-034 nrst asserted in RD1 -> all outputs reset values immediately, no rsp_valid after release.
